dot_rect_layer_gen: RTL
=======================

Name: dot_rect_layer_gen

Overview:
Multi-rectangle successor to the single-square dot generator. It holds pRectNum independently configurable rectangles, each with its own colour and draw mode: off, fill, outline or blinking fill. Configuration is double-buffered and swapped at frame start, so edits made mid-frame never tear the image. The block sits in the VT unit pixel path, driven by the timing generator's H/V position. It outputs one priority-resolved pixel per cycle; a colour of all-zero means transparent.

Parameters:
pHdisplayWidth, 11, width of horizontal coordinate
pVdisplayWidth, 11, width of vertical coordinate
pColorDepth, 16, pixel width
pRectNum, 4, number of rectangles (1..16)
pIdxWidth, 2, width of rectangle index; must satisfy 2**pIdxWidth >= pRectNum
pLineW, 2, outline thickness in pixels (>=1)
pBlinkBit, 5, frame-counter bit that gates blink mode

Ports:
iClk  in  1  system clock
iRst  in  1  reset; synchronous, active-high
iHpos  in  pHdisplayWidth  current X position
iVpos  in  pVdisplayWidth  current Y position
iPosValid  in  1  iHpos/iVpos valid this cycle (active video)
iFrameStart  in  1  one-cycle pulse at start of frame
iWe  in  1  configuration write strobe
iWIdx  in  pIdxWidth  rectangle index being written
iWDxs  in  pHdisplayWidth  X start, inclusive
iWDxe  in  pHdisplayWidth  X end, exclusive
iWDys  in  pVdisplayWidth  Y start, inclusive
iWDye  in  pVdisplayWidth  Y end, exclusive
iWColor  in  pColorDepth  rectangle colour
iWMode  in  2  0 off, 1 fill, 2 outline, 3 blink-fill
oPixel  out  pColorDepth  resolved pixel; 0 = transparent
oPixelValid  out  1  oPixel valid (iPosValid delayed 2 cycles)
oHit  out  1  some rectangle covers this pixel
oHitIdx  out  pIdxWidth  index of the winning rectangle (0 when oHit=0)

Behaviour:
- Reset: all pending and active entries cleared (mode 0, coordinates 0, colour 0). Frame counter = 0. oPixel = 0, oPixelValid = 0, oHit = 0, oHitIdx = 0. Both pipeline stages cleared.
- Writes: when iWe=1, the pending entry at iWIdx takes all W* fields on the clock edge. iWIdx >= pRectNum: write ignored, no side effect.
- Swap: when iFrameStart=1, every active entry takes its pending value and the frame counter (pBlinkBit+1 bits) increments, wrapping freely.
- iWe and iFrameStart in the same cycle: the write lands in pending only. The active bank receives the pre-write pending value. The write therefore takes effect at the next frame start.
- Area test per rectangle: Dxs <= Hpos < Dxe and Dys <= Vpos < Dye. Dxs >= Dxe or Dys >= Dye gives an empty rectangle that never hits.
- Outline test: area test AND (Hpos < Dxs+pLineW OR Hpos >= Dxe-pLineW OR Vpos < Dys+pLineW OR Vpos >= Dye-pLineW).
  - Sums and differences are computed one bit wider than the coordinate. A negative Dxe-pLineW clamps to 0; there is no wrap-around.
  - A rectangle thinner than 2*pLineW renders fully filled.
- Blink-fill: hits as fill only while frameCnt[pBlinkBit]=0. Otherwise no hit.
- Pipeline stage 1: register per-rectangle hit bits (mode-qualified) together with iPosValid.
- Pipeline stage 2: lowest index with a hit wins. oPixel = that rectangle's active colour, oHit = 1, oHitIdx = index. With no hit: oPixel = 0, oHit = 0, oHitIdx = 0. When the stage-1 valid is 0, oPixel = 0 and oHit = 0.
- Latency: iHpos/iVpos to oPixel is exactly 2 cycles. Throughput is 1 pixel per cycle.
- Stage 1 samples the active bank. A swap therefore affects pixels sampled from the cycle after iFrameStart onward.
- Reset asserted mid-frame: outputs read 0 the cycle after reset and stay 0 until a frame start loads a new configuration.

Test Plan:
- Reset, then write idx0 = (10,20,5,8), colour 0xF800, fill; pulse iFrameStart; scan line V=5 -> oPixel = 0xF800 exactly for H=10..19, 0 elsewhere; output lags the position input by 2 cycles.
- Overlap: idx0 fill 0x001F at (0,8,0,8) and idx1 fill 0x07E0 at (4,12,0,8) -> H=4..7 gives 0x001F with oHitIdx=0; H=8..11 gives 0x07E0 with oHitIdx=1.
- Outline pLineW=2, rectangle (0,10,0,10): V=5 -> hits at H=0,1,8,9 only; V=0 -> hits at H=0..9.
- Write idx0 mid-frame, no frame start -> output unchanged. Pulse iFrameStart together with iWe to idx1 -> idx0 update visible, idx1 update not visible until the following frame start.
- Blink pBlinkBit=0: 4 frame starts -> rectangle visible in frames with frameCnt=0,2 and hidden in frames with frameCnt=1,3.
- Degenerate cases: Dxs=Dxe, iWIdx=pRectNum write, and iRst mid-scan -> no hit, no state change, outputs 0 respectively.

Source files
------------

// File: rtl/dot_rect_layer_gen.sv
// Priority-resolved multi-rectangle overlay for the VT pixel path.
// Double-buffered per-rectangle config; two-stage pipeline from position to pixel.
module dot_rect_layer_gen #(
   parameter int pHdisplayWidth = 11,
   parameter int pVdisplayWidth = 11,
   parameter int pColorDepth    = 16,
   parameter int pRectNum       = 4,
   parameter int pIdxWidth      = 2,
   parameter int pLineW         = 2,
   parameter int pBlinkBit      = 5
)(
   input  logic                      iClk,
   input  logic                      iRst,
   input  logic [pHdisplayWidth-1:0] iHpos,
   input  logic [pVdisplayWidth-1:0] iVpos,
   input  logic                      iPosValid,
   input  logic                      iFrameStart,
   input  logic                      iWe,
   input  logic [pIdxWidth-1:0]      iWIdx,
   input  logic [pHdisplayWidth-1:0] iWDxs,
   input  logic [pHdisplayWidth-1:0] iWDxe,
   input  logic [pVdisplayWidth-1:0] iWDys,
   input  logic [pVdisplayWidth-1:0] iWDye,
   input  logic [pColorDepth-1:0]    iWColor,
   input  logic [1:0]                iWMode,
   output logic [pColorDepth-1:0]    oPixel,
   output logic                      oPixelValid,
   output logic                      oHit,
   output logic [pIdxWidth-1:0]      oHitIdx
);
   localparam int HW = pHdisplayWidth + 1;
   localparam int VW = pVdisplayWidth + 1;
   localparam logic [HW-1:0] LW_H = HW'(pLineW);
   localparam logic [VW-1:0] LW_V = VW'(pLineW);

   logic [pHdisplayWidth-1:0] p_xs_r [pRectNum];
   logic [pHdisplayWidth-1:0] p_xe_r [pRectNum];
   logic [pVdisplayWidth-1:0] p_ys_r [pRectNum];
   logic [pVdisplayWidth-1:0] p_ye_r [pRectNum];
   logic [pColorDepth-1:0]    p_color_r [pRectNum];
   logic [1:0]                p_mode_r [pRectNum];
   logic [pHdisplayWidth-1:0] a_xs_r [pRectNum];
   logic [pHdisplayWidth-1:0] a_xe_r [pRectNum];
   logic [pVdisplayWidth-1:0] a_ys_r [pRectNum];
   logic [pVdisplayWidth-1:0] a_ye_r [pRectNum];
   logic [pColorDepth-1:0]    a_color_r [pRectNum];
   logic [1:0]                a_mode_r [pRectNum];

   logic [pBlinkBit:0]        frame_cnt_r;
   logic [pRectNum-1:0]       hit_s;
   logic [pRectNum-1:0]       hit_r;
   logic                      valid1_r;
   logic                      win_s;
   logic [pIdxWidth-1:0]      win_idx_s;
   logic [pColorDepth-1:0]    win_color_s;
   logic                      wr_ok_s;

   assign wr_ok_s = iWe && (32'(iWIdx) < 32'(pRectNum));

   // Pending/active banks and frame counter; active copies the pre-edge pending value.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         for (int i = 0; i < pRectNum; i++) begin
            p_xs_r[i]    <= '0;
            p_xe_r[i]    <= '0;
            p_ys_r[i]    <= '0;
            p_ye_r[i]    <= '0;
            p_color_r[i] <= '0;
            p_mode_r[i]  <= 2'd0;
            a_xs_r[i]    <= '0;
            a_xe_r[i]    <= '0;
            a_ys_r[i]    <= '0;
            a_ye_r[i]    <= '0;
            a_color_r[i] <= '0;
            a_mode_r[i]  <= 2'd0;
         end
         frame_cnt_r <= '0;
      end else begin
         for (int i = 0; i < pRectNum; i++) begin
            if (wr_ok_s && (iWIdx == pIdxWidth'(i))) begin
               p_xs_r[i]    <= iWDxs;
               p_xe_r[i]    <= iWDxe;
               p_ys_r[i]    <= iWDys;
               p_ye_r[i]    <= iWDye;
               p_color_r[i] <= iWColor;
               p_mode_r[i]  <= iWMode;
            end
            if (iFrameStart) begin
               a_xs_r[i]    <= p_xs_r[i];
               a_xe_r[i]    <= p_xe_r[i];
               a_ys_r[i]    <= p_ys_r[i];
               a_ye_r[i]    <= p_ye_r[i];
               a_color_r[i] <= p_color_r[i];
               a_mode_r[i]  <= p_mode_r[i];
            end
         end
         if (iFrameStart) begin
            frame_cnt_r <= frame_cnt_r + (pBlinkBit+1)'(1);
         end
      end
   end

   for (genvar g = 0; g < pRectNum; g++) begin : g_rect
      logic [HW-1:0] h_s, xs_s, xe_s, xs_in_s, xe_in_s;
      logic [VW-1:0] v_s, ys_s, ye_s, ys_in_s, ye_in_s;
      logic          area_s, edge_s;

      assign h_s  = {1'b0, iHpos};
      assign v_s  = {1'b0, iVpos};
      assign xs_s = {1'b0, a_xs_r[g]};
      assign xe_s = {1'b0, a_xe_r[g]};
      assign ys_s = {1'b0, a_ys_r[g]};
      assign ye_s = {1'b0, a_ye_r[g]};
      // Inner edges are one bit wider; the far edge clamps at 0 instead of wrapping.
      assign xs_in_s = xs_s + LW_H;
      assign ys_in_s = ys_s + LW_V;
      assign xe_in_s = (xe_s >= LW_H) ? (xe_s - LW_H) : '0;
      assign ye_in_s = (ye_s >= LW_V) ? (ye_s - LW_V) : '0;
      assign area_s  = (h_s >= xs_s) && (h_s < xe_s) && (v_s >= ys_s) && (v_s < ye_s);
      assign edge_s  = (h_s < xs_in_s) || (h_s >= xe_in_s) ||
                       (v_s < ys_in_s) || (v_s >= ye_in_s);
      assign hit_s[g] = (a_mode_r[g] == 2'd1) ? area_s :
                        (a_mode_r[g] == 2'd2) ? (area_s && edge_s) :
                        (a_mode_r[g] == 2'd3) ? (area_s && !frame_cnt_r[pBlinkBit]) :
                        1'b0;
   end

   // Stage 1: mode-qualified hit vector and position valid.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         hit_r    <= '0;
         valid1_r <= 1'b0;
      end else begin
         hit_r    <= iPosValid ? hit_s : '0;
         valid1_r <= iPosValid;
      end
   end

   // Lowest-index priority select; scanning downward leaves the lowest hit last.
   always_comb begin
      win_s       = 1'b0;
      win_idx_s   = '0;
      win_color_s = '0;
      for (int i = pRectNum - 1; i >= 0; i--) begin
         if (hit_r[i]) begin
            win_s       = 1'b1;
            win_idx_s   = pIdxWidth'(i);
            win_color_s = a_color_r[i];
         end else begin
            win_s       = win_s;
         end
      end
   end

   // Stage 2: registered pixel outputs.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         oPixel      <= '0;
         oPixelValid <= 1'b0;
         oHit        <= 1'b0;
         oHitIdx     <= '0;
      end else begin
         oPixelValid <= valid1_r;
         if (valid1_r && win_s) begin
            oPixel  <= win_color_s;
            oHit    <= 1'b1;
            oHitIdx <= win_idx_s;
         end else begin
            oPixel  <= '0;
            oHit    <= 1'b0;
            oHitIdx <= '0;
         end
      end
   end
endmodule
